// File: rtl/ahb_arbiter_slave_pkg.sv
// ----------------------------------------------------------------------------
// AHB_package
// Shared types and helpers for the AHB interconnect arbiters.
//   arb_state_t  : slave-side arbiter FSM state (IDLE / OWNED)
//   MAX_CHANNELS : largest number of masters an arbiter may serve
//   onehot2idx   : index of the set bit in a one-hot vector (0 for all-zero)
// ----------------------------------------------------------------------------
package AHB_package;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int MAX_CHANNELS = 16;

    // OR-reduction of the indices of all set bits. For a one-hot input this is
    // the index of the set bit; for an all-zero input it is 0.
    function automatic int onehot2idx(input logic [MAX_CHANNELS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arbiter_slave_rr_pick.sv
// ----------------------------------------------------------------------------
// ahb_rr_pick
// Combinational round-robin picker. The search starts at ptr and walks
// ptr, ptr+1, ... wrapping modulo CHANNEL_NUM; the first requester wins.
// Implemented as rotate (so ptr lands on bit 0), lowest-bit search, and
// unrotate of the found offset back to an absolute master index.
// Ports:
//   req           in  [CHANNEL_NUM] request vector
//   ptr           in  [IDX_W]       highest-priority master (must be < CHANNEL_NUM)
//   winner_onehot out [CHANNEL_NUM] one-hot winner, zero when no request
//   winner_idx    out [IDX_W]       winner index, 0 when no request
//   any           out               at least one request present
// ----------------------------------------------------------------------------
module ahb_rr_pick #(
    parameter int CHANNEL_NUM = 2,
    parameter int IDX_W       = $clog2(CHANNEL_NUM)
) (
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [CHANNEL_NUM-1:0] winner_onehot,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   any
);

    // (a + b) mod CHANNEL_NUM for a, b < CHANNEL_NUM. One conditional subtract
    // suffices and keeps non-power-of-2 sizes inside the legal index range.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (IDX_W+1)'(CHANNEL_NUM)) begin
            sum = sum - (IDX_W+1)'(CHANNEL_NUM);
        end
        return sum[IDX_W-1:0];
    endfunction

    logic [CHANNEL_NUM-1:0] req_rot;
    logic [IDX_W-1:0]       offset;
    logic                   found;

    // Rotate: req_rot[i] is the request of master (ptr + i) mod CHANNEL_NUM.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            req_rot[i] = req[wrap_add(ptr, IDX_W'(i))];
        end
    end

    // Search: lowest set bit of the rotated vector.
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (!found && req_rot[i]) begin
                found  = 1'b1;
                offset = IDX_W'(i);
            end
        end
    end

    // Unrotate.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        if (found) begin
            winner_idx                = wrap_add(ptr, offset);
            winner_onehot[winner_idx] = 1'b1;
        end
    end

    assign any = found;

endmodule

// File: rtl/ahb_arbiter_slave.sv
// ----------------------------------------------------------------------------
// ahb_arbiter_slave
// Per-slave round-robin arbiter. Decides which master owns the slave's
// address phase and produces one-hot selects for the request mux (grant) and
// the response mux (data_sel).
//
// Transfer handshake: hready_in is the slave HREADYOUT. A cycle whose rising
// edge sees hready_in=1 completes the current address and data phases; only on
// such edges may grant, data_sel, hmaster, ptr or the FSM change. A master
// asserts req[i] and holds it until it is granted; an address phase counts as
// accepted on a hready_in=1 edge where both grant[i] and req[i] are high.
//
// Ports:
//   hclk, hreset  clock and synchronous active-high reset
//   req           [CHANNEL_NUM] master i has a transfer decoded to this slave
//   lock          [CHANNEL_NUM] master i must keep ownership (lock / burst)
//   hready_in     slave HREADYOUT
//   grant         [CHANNEL_NUM] registered one-hot/zero address-phase owner
//   data_sel      [CHANNEL_NUM] registered one-hot/zero data-phase owner
//   hmaster       [IDX_W]       index of the grant bit, 0 when idle
//   wait_req      [CHANNEL_NUM] req & ~grant, stalls waiting masters
//   dbg_state     FSM state
//   dbg_ptr       [IDX_W]       round-robin pointer
// ----------------------------------------------------------------------------
module ahb_arbiter_slave
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 2,
    parameter int IDX_W       = $clog2(CHANNEL_NUM)
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [CHANNEL_NUM-1:0] lock,
    input  logic                   hready_in,
    output logic [CHANNEL_NUM-1:0] grant,
    output logic [CHANNEL_NUM-1:0] data_sel,
    output logic [IDX_W-1:0]       hmaster,
    output logic [CHANNEL_NUM-1:0] wait_req,
    output arb_state_t             dbg_state,
    output logic [IDX_W-1:0]       dbg_ptr
);

    arb_state_t             state_q, state_d;
    logic [CHANNEL_NUM-1:0] grant_q, grant_d;
    logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
    logic [IDX_W-1:0]       hmaster_q, hmaster_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic [CHANNEL_NUM-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [IDX_W:0]         pick_inc;
    logic [IDX_W-1:0]       ptr_after;
    logic                   owner_locked;

    ahb_rr_pick #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req           (req),
        .ptr           (ptr_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx),
        .any           (pick_any)
    );

    // Pointer moves just past the winner so the winner becomes lowest priority.
    assign pick_inc  = {1'b0, pick_idx} + (IDX_W+1)'(1);
    assign ptr_after = (pick_inc == (IDX_W+1)'(CHANNEL_NUM)) ? '0 : pick_inc[IDX_W-1:0];

    // A lock only counts while its owner still requests; a locked owner that
    // has dropped req would otherwise hold the slave forever.
    assign owner_locked = lock[hmaster_q] & req[hmaster_q];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        data_sel_d = data_sel_q;
        ptr_d      = ptr_q;
        hmaster_d  = hmaster_q;

        if (hready_in) begin
            data_sel_d = grant_q & req;
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_d = ARB_OWNED;
                        grant_d = pick_onehot;
                        ptr_d   = ptr_after;
                    end
                end
                ARB_OWNED: begin
                    if (!owner_locked) begin
                        if (pick_any) begin
                            grant_d = pick_onehot;
                            ptr_d   = ptr_after;
                        end else begin
                            state_d = ARB_IDLE;
                            grant_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            endcase
            hmaster_d = IDX_W'(onehot2idx(MAX_CHANNELS'(grant_d)));
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            data_sel_q <= '0;
            hmaster_q  <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            data_sel_q <= data_sel_d;
            hmaster_q  <= hmaster_d;
            ptr_q      <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign data_sel  = data_sel_q;
    assign hmaster   = hmaster_q;
    assign wait_req  = req & ~grant_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule
